// File: rtl/pm_boot_loader.sv
// pm_boot_loader: boot-time program-memory loader.
// Accepts a host byte stream (16-bit word count, N words, XOR checksum).
// Assembles PMD_SIZE-bit words and writes them sequentially into program memory.
// Releases the core only after the stream checksum matches.
module pm_boot_loader #(
    parameter int PMA_SIZE  = 16,
    parameter int PMD_SIZE  = 32,
    parameter int PM_DEPTH  = 4096,
    parameter int BOOT_BASE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic                pm_wr_en,
    output logic [PMA_SIZE-1:0] pm_wr_add,
    output logic [PMD_SIZE-1:0] pm_wr_dt,
    output logic                core_run,
    output logic                boot_busy,
    output logic                boot_done,
    output logic                boot_err,
    output logic [1:0]          err_code
);

    localparam int BPW = PMD_SIZE / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    state_t              state_r;
    state_t              next_s;
    logic                rx_ready_r;
    logic                pm_wr_en_r;
    logic [PMA_SIZE-1:0] pm_wr_add_r;
    logic [PMD_SIZE-1:0] pm_wr_dt_r;
    logic                core_run_r;
    logic                boot_busy_r;
    logic                boot_done_r;
    logic                boot_err_r;
    logic [1:0]          err_code_r;
    logic [7:0]          xor_r;
    logic [7:0]          hdr_hi_r;
    logic [15:0]         n_r;
    logic [15:0]         word_cnt_r;
    logic [BCW-1:0]      byte_cnt_r;
    logic [PMD_SIZE-1:0] shift_r;

    logic                accept_s;
    logic [15:0]         hdr_n_s;
    logic                last_byte_s;
    logic                last_word_s;
    logic [PMD_SIZE-1:0] word_s;
    logic                restart_s;
    logic                rx_ready_s;
    logic                core_run_s;
    logic                boot_busy_s;
    logic                boot_err_s;
    logic [1:0]          err_code_s;

    // rx_ready_r tracks the accepting states, so this is the byte handshake
    assign accept_s    = rx_valid & rx_ready_r;
    assign hdr_n_s     = {hdr_hi_r, rx_data};
    assign last_byte_s = (byte_cnt_r == BCW'(BPW - 1));
    assign last_word_s = (word_cnt_r == (n_r - 16'd1));
    assign word_s      = (shift_r << 8) | PMD_SIZE'(rx_data);
    assign restart_s   = ((state_r == ST_IDLE) || (state_r == ST_ERROR)) && (next_s == ST_HDR_HI);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode; the length check happens as the header low byte arrives
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_s = ST_HDR_HI;
                else       next_s = ST_IDLE;
            end
            ST_HDR_HI: begin
                if (accept_s) next_s = ST_HDR_LO;
                else          next_s = ST_HDR_HI;
            end
            ST_HDR_LO: begin
                if (!accept_s)                    next_s = ST_HDR_LO;
                else if (hdr_n_s == 16'd0)        next_s = ST_CHK;
                else if (32'(hdr_n_s) > PM_DEPTH) next_s = ST_ERROR;
                else                              next_s = ST_DATA;
            end
            ST_DATA: begin
                if (accept_s && last_byte_s && last_word_s) next_s = ST_CHK;
                else                                        next_s = ST_DATA;
            end
            ST_CHK: begin
                if (!accept_s)              next_s = ST_CHK;
                else if (xor_r == rx_data)  next_s = ST_DONE;
                else                        next_s = ST_ERROR;
            end
            ST_DONE:  next_s = ST_DONE;
            ST_ERROR: begin
                if (start) next_s = ST_ERROR == ST_ERROR ? ST_HDR_HI : ST_ERROR;
                else       next_s = ST_ERROR;
            end
            default:  next_s = ST_IDLE;
        endcase
    end

    // Status decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        rx_ready_s  = (next_s == ST_HDR_HI) || (next_s == ST_HDR_LO) ||
                      (next_s == ST_DATA)   || (next_s == ST_CHK);
        boot_busy_s = rx_ready_s;
        core_run_s  = (next_s == ST_DONE);
        boot_err_s  = (next_s == ST_ERROR);
        if ((state_r == ST_HDR_LO) && (next_s == ST_ERROR)) begin
            err_code_s = 2'b01;
        end else if ((state_r == ST_CHK) && (next_s == ST_ERROR)) begin
            err_code_s = 2'b10;
        end else if (next_s == ST_HDR_HI) begin
            err_code_s = 2'b00;
        end else begin
            err_code_s = err_code_r;
        end
    end

    // Registered status outputs; boot_done is sticky until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ready_r  <= 1'b0;
            core_run_r  <= 1'b0;
            boot_busy_r <= 1'b0;
            boot_done_r <= 1'b0;
            boot_err_r  <= 1'b0;
            err_code_r  <= 2'b00;
        end else begin
            rx_ready_r  <= rx_ready_s;
            core_run_r  <= core_run_s;
            boot_busy_r <= boot_busy_s;
            boot_done_r <= boot_done_r | core_run_s;
            boot_err_r  <= boot_err_s;
            err_code_r  <= err_code_s;
        end
    end

    // Datapath: checksum, header capture, word assembly, PM write strobe and address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xor_r       <= 8'h00;
            hdr_hi_r    <= 8'h00;
            n_r         <= 16'd0;
            word_cnt_r  <= 16'd0;
            byte_cnt_r  <= '0;
            shift_r     <= '0;
            pm_wr_en_r  <= 1'b0;
            pm_wr_add_r <= PMA_SIZE'(BOOT_BASE);
            pm_wr_dt_r  <= '0;
        end else begin
            pm_wr_en_r <= 1'b0;
            if (restart_s) begin
                xor_r       <= 8'h00;
                word_cnt_r  <= 16'd0;
                byte_cnt_r  <= '0;
                pm_wr_add_r <= PMA_SIZE'(BOOT_BASE);
            end else begin
                // the address moves on the edge that ends the write strobe cycle
                if (pm_wr_en_r) begin
                    pm_wr_add_r <= pm_wr_add_r + PMA_SIZE'(1);
                end else begin
                    pm_wr_add_r <= pm_wr_add_r;
                end
                if (accept_s) begin
                    xor_r <= xor_r ^ rx_data;
                    case (state_r)
                        ST_HDR_HI: hdr_hi_r <= rx_data;
                        ST_HDR_LO: n_r      <= hdr_n_s;
                        ST_DATA: begin
                            shift_r <= word_s;
                            if (last_byte_s) begin
                                byte_cnt_r <= '0;
                                word_cnt_r <= word_cnt_r + 16'd1;
                                pm_wr_en_r <= 1'b1;
                                pm_wr_dt_r <= word_s;
                            end else begin
                                byte_cnt_r <= byte_cnt_r + BCW'(1);
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    xor_r <= xor_r;
                end
            end
        end
    end

    assign rx_ready  = rx_ready_r;
    assign pm_wr_en  = pm_wr_en_r;
    assign pm_wr_add = pm_wr_add_r;
    assign pm_wr_dt  = pm_wr_dt_r;
    assign core_run  = core_run_r;
    assign boot_busy = boot_busy_r;
    assign boot_done = boot_done_r;
    assign boot_err  = boot_err_r;
    assign err_code  = err_code_r;

endmodule

// File: tb/tb_pm_boot_loader.sv
// Directed bench for pm_boot_loader (PMD_SIZE=32, PM_DEPTH=4 so the length error is reachable).
module tb_pm_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        pm_wr_en;
    logic [15:0] pm_wr_add;
    logic [31:0] pm_wr_dt;
    logic        core_run;
    logic        boot_busy;
    logic        boot_done;
    logic        boot_err;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int wr_cnt = 0;
    int acc0;
    int wr0;

    pm_boot_loader #(
        .PMA_SIZE(16), .PMD_SIZE(32), .PM_DEPTH(4), .BOOT_BASE(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .pm_wr_en(pm_wr_en), .pm_wr_add(pm_wr_add), .pm_wr_dt(pm_wr_dt),
        .core_run(core_run), .boot_busy(boot_busy), .boot_done(boot_done),
        .boot_err(boot_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Count transferred bytes and PM write strobes between edges
    always @(negedge clk) begin
        if (rx_valid && rx_ready) acc_cnt = acc_cnt + 1;
        if (pm_wr_en) wr_cnt = wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Two-word stream 00 02 12345678 DEADBEEF <ck>, back-to-back, checking both writes
    task automatic nominal_stream(input logic [7:0] ck, input bit start_mid);
        send(8'h00); send(8'h02);
        send(8'h12); send(8'h34);
        start = start_mid;
        send(8'h56);
        start = 1'b0;
        check("busy_after_start_in_data", {31'd0, boot_busy}, 32'd1);
        send(8'h78);
        check("w0_en", {31'd0, pm_wr_en}, 32'd1);
        check("w0_add", {16'd0, pm_wr_add}, 32'd0);
        check("w0_dt", pm_wr_dt, 32'h12345678);
        send(8'hDE);
        check("w0_strobe_one_cycle", {31'd0, pm_wr_en}, 32'd0);
        check("add_incr", {16'd0, pm_wr_add}, 32'd1);
        send(8'hAD); send(8'hBE); send(8'hEF);
        check("w1_en", {31'd0, pm_wr_en}, 32'd1);
        check("w1_add", {16'd0, pm_wr_add}, 32'd1);
        check("w1_dt", pm_wr_dt, 32'hDEADBEEF);
        check("chk_core_held", {31'd0, core_run}, 32'd0);
        send(ck);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(); tick();
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_wr_en", {31'd0, pm_wr_en}, 32'd0);
        check("rst_add", {16'd0, pm_wr_add}, 32'd0);
        check("rst_dt", pm_wr_dt, 32'd0);
        check("rst_flags", {27'd0, core_run, boot_busy, boot_done, boot_err, 1'b0}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        reset = 1'b1;
        tick();

        // rx_valid in IDLE is ignored
        acc0 = acc_cnt;
        rx_valid = 1'b1; rx_data = 8'hAA;
        tick(); tick(); tick();
        rx_valid = 1'b0;
        check("idle_no_accept", acc_cnt - acc0, 32'd0);
        check("idle_rx_ready", {31'd0, rx_ready}, 32'd0);

        // Nominal boot with a start pulse during DATA
        wr0 = wr_cnt; acc0 = acc_cnt;
        pulse_start();
        check("start_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("start_busy", {31'd0, boot_busy}, 32'd1);
        nominal_stream(8'h28, 1'b1);
        check("nom_core_run", {31'd0, core_run}, 32'd1);
        check("nom_done", {31'd0, boot_done}, 32'd1);
        check("nom_busy", {31'd0, boot_busy}, 32'd0);
        check("nom_err", {31'd0, boot_err}, 32'd0);
        check("nom_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("nom_writes", wr_cnt - wr0, 32'd2);
        check("nom_accepts", acc_cnt - acc0, 32'd11);

        // DONE ignores start and rx_valid
        acc0 = acc_cnt;
        pulse_start();
        rx_valid = 1'b1; rx_data = 8'h55;
        tick(); tick();
        rx_valid = 1'b0;
        check("done_start_ign_run", {31'd0, core_run}, 32'd1);
        check("done_start_ign_busy", {31'd0, boot_busy}, 32'd0);
        check("done_no_accept", acc_cnt - acc0, 32'd0);

        // Reset from DONE drops core_run without a clock edge
        reset = 1'b0;
        #1;
        check("async_core_run", {31'd0, core_run}, 32'd0);
        check("async_done", {31'd0, boot_done}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Checksum error, then a retry from ERROR
        wr0 = wr_cnt;
        pulse_start();
        nominal_stream(8'h29, 1'b0);
        check("cks_err", {31'd0, boot_err}, 32'd1);
        check("cks_code", {30'd0, err_code}, 32'd2);
        check("cks_core_run", {31'd0, core_run}, 32'd0);
        check("cks_writes", wr_cnt - wr0, 32'd2);
        pulse_start();
        check("retry_code_clr", {30'd0, err_code}, 32'd0);
        check("retry_err_clr", {31'd0, boot_err}, 32'd0);
        nominal_stream(8'h28, 1'b0);
        check("retry_done", {31'd0, boot_done}, 32'd1);
        check("retry_run", {31'd0, core_run}, 32'd1);

        // Length error: N=5 > PM_DEPTH=4
        do_reset();
        wr0 = wr_cnt;
        pulse_start();
        send(8'h00); send(8'h05);
        rx_valid = 1'b0;
        check("len_err", {31'd0, boot_err}, 32'd1);
        check("len_code", {30'd0, err_code}, 32'd1);
        check("len_rx_ready", {31'd0, rx_ready}, 32'd0);
        tick(); tick();
        check("len_no_write", wr_cnt - wr0, 32'd0);

        // Zero length from ERROR with rx_valid toggling every cycle
        acc0 = acc_cnt;
        pulse_start();
        send(8'h00); rx_valid = 1'b0; tick();
        send(8'h00); rx_valid = 1'b0; tick();
        check("zero_not_done_yet", {31'd0, boot_done}, 32'd0);
        send(8'h00); rx_valid = 1'b0;
        check("zero_done", {31'd0, boot_done}, 32'd1);
        check("zero_run", {31'd0, core_run}, 32'd1);
        check("zero_accepts", acc_cnt - acc0, 32'd3);
        check("zero_no_write", wr_cnt - wr0, 32'd0);

        // Reset after 5 payload bytes, then a fresh boot starts again at BOOT_BASE
        do_reset();
        pulse_start();
        send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'hDE);
        rx_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
        check("mid_rst_busy", {31'd0, boot_busy}, 32'd0);
        check("mid_rst_add", {16'd0, pm_wr_add}, 32'd0);
        check("mid_rst_dt", pm_wr_dt, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        pulse_start();
        nominal_stream(8'h28, 1'b0);
        check("fresh_done", {31'd0, boot_done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
